data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
- Parametrised data-memory access unit for the CPU memory stage, the successor to the fixed word-only BRAM hookup.
- Accepts one load/store request at a time over a valid/ready handshake and supports byte, halfword and word sizes.
- Loads are sign- or zero-extended; stores drive per-lane byte enables.
- Hides a configurable BRAM read latency, and flags misaligned or out-of-range accesses instead of touching memory.

Parameters:
- ADDR_W, 18, BRAM word-address width; the byte address space is 2^(ADDR_W+2).
- READ_LATENCY, 1, BRAM clock-to-dout latency in cycles, 1..4.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  qualifies resp_valid: misaligned, out-of-range or illegal size
- resp_rdata  out  32  load result; 0 for stores and errors
- bram_addr  out  ADDR_W  registered word address
- bram_din  out  32  registered lane-replicated write data
- bram_we  out  4  registered byte write enables; bit i = byte lane i
- bram_dout  in  32  BRAM read data

Behaviour:
- Reset (async, rstn=0):
  - state IDLE
  - req_ready=0 while in reset, 1 once rstn is high and state is IDLE
  - resp_valid=0, resp_err=0, resp_rdata=0
  - bram_we=0, bram_addr=0, bram_din=0
  - wait counter cleared
- Reset mid-operation aborts the request with no response.
  - Because bram_we clears asynchronously, a store may be lost; this is acceptable.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - req_ready=1 only in IDLE, so there is no pipelining and at most one request is outstanding.
- Error check at accept (combinational on the request):
  - err if size==11
  - err if size==01 && addr[0]
  - err if size==10 && addr[1:0]!=0
  - err if addr[31:ADDR_W+2]!=0
  - On err, the BRAM is not touched (bram_we stays 0).
- States: IDLE, ISSUE, WAIT, RESP.
- Transitions:
  - IDLE -> RESP on an erroring accept.
  - IDLE -> ISSUE on a good accept; this registers bram_addr=addr[ADDR_W+1:2] and, for stores, bram_we/bram_din.
  - ISSUE -> RESP for a store; bram_we is high only in the ISSUE cycle.
  - ISSUE -> WAIT for a load.
  - WAIT lasts READ_LATENCY cycles. On its last cycle, the aligned and extended bram_dout is registered into resp_rdata, then the state moves to RESP.
  - RESP -> IDLE; resp_valid=1 for exactly this cycle.
- Latency (accept in cycle T):
  - error response in cycle T+1
  - store response in cycle T+2
  - load response in cycle T+2+READ_LATENCY
- Lanes are little-endian; lane = addr[1:0].
  - Byte store: bram_din = {4{wdata[7:0]}}, bram_we = 1<<lane.
  - Half store: bram_din = {2{wdata[15:0]}}, bram_we = 0011 or 1100.
  - Word store: bram_we = 1111.
- Load extraction:
  - select the byte or half at the lane
  - extend with the MSB if req_signed, else zeros
  - req_signed is ignored for word loads
- resp_rdata holds its value until the next response. It is forced to 0 on store and error responses.

Decomposition:
- Package dmem_pkg: size enum (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, and a lane-select helper.
- Sub-module load_align (combinational): inputs bram_dout, lane, size, signed; output the 32-bit extended value. It is reused later by the MMIO path.

Test Plan:
- Word store then load: store addr 0x10, wdata 0xDEADBEEF.
  - bram_we=1111 and bram_addr=4 in cycle T+1; response at T+2.
  - Load of 0x10 returns 0xDEADBEEF at T+3 (READ_LATENCY=1).
- Byte store at 0x13 with wdata 0x000000A5: bram_we=1000, bram_din=0xA5A5A5A5.
  - Load byte signed at 0x13 -> 0xFFFFFFA5.
  - Load byte unsigned -> 0x000000A5.
- Half load at 0x12 of word 0x8001xxxx: signed -> 0xFFFF8001, unsigned -> 0x00008001.
- Error cases, each giving resp_err=1, resp_rdata=0, resp_valid at T+1 and bram_we never asserted:
  - word load at 0x2
  - half store at 0x1
  - size 11
  - address 0x00100000 with ADDR_W=18
- READ_LATENCY=3 bench: load response at exactly T+5; req_ready=0 from T+1 through T+5; req_valid held high is not accepted again until T+6.
- rstn pulsed low during a load WAIT cycle: no resp_valid, all outputs 0 immediately; the next request after reset completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane helper for the data-memory access unit
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Byte lanes touched by an access of the given size at the given lane.
    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_unit_load_align.sv
// rtl/data_mem_unit_load_align.sv - picks the addressed byte/half from a BRAM word and extends it
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Little-endian lane selection followed by sign or zero extension.
    always_comb begin
        byte_v = dout[{lane, 3'b000} +: 8];
        half_v = lane[1] ? dout[31:16] : dout[15:0];
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{sign_ext & half_v[15]}}, half_v};
            default: data = dout;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - single-outstanding load/store unit in front of a fixed-latency BRAM
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic [3:0]        bram_we,
    input  logic [31:0]       bram_dout
);

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_e      state;
    logic [1:0]  wait_cnt;
    logic [1:0]  lane_q;
    size_e       size_q;
    logic        sign_q;
    logic        we_q;
    size_e       req_sz;
    logic        req_err;
    logic        accept;
    logic [31:0] store_din;
    logic [31:0] aligned;

    assign req_sz    = size_e'(req_size);
    assign req_ready = rstn && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // Reject illegal sizes, misalignment and addresses beyond the BRAM before anything is touched.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b11:   req_err = 1'b1;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b0;
        endcase
        if ((req_addr >> (ADDR_W + 2)) != 32'd0) begin
            req_err = 1'b1;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        case (req_sz)
            SZ_BYTE: store_din = {4{req_wdata[7:0]}};
            SZ_HALF: store_din = {2{req_wdata[15:0]}};
            default: store_din = req_wdata;
        endcase
    end

    load_align u_load_align (
        .dout     (bram_dout),
        .lane     (lane_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .data     (aligned)
    );

    // Request sequencer: accept, drive the BRAM for one cycle, sit out the read latency, respond.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            wait_cnt   <= 2'd0;
            lane_q     <= 2'd0;
            size_q     <= SZ_BYTE;
            sign_q     <= 1'b0;
            we_q       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            bram_addr  <= '0;
            bram_din   <= 32'd0;
            bram_we    <= 4'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            bram_we    <= 4'd0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lane_q <= req_addr[1:0];
                        size_q <= req_sz;
                        sign_q <= req_signed;
                        we_q   <= req_we;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            state      <= ST_RESP;
                        end else begin
                            bram_addr <= req_addr[ADDR_W+1:2];
                            if (req_we) begin
                                bram_we  <= lane_mask(req_sz, req_addr[1:0]);
                                bram_din <= store_din;
                            end
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (we_q) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        state      <= ST_RESP;
                    end else begin
                        wait_cnt <= 2'd0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= aligned;
                        state      <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - randomized and directed bench for data_mem_unit at read latencies 1 and 3
module tb_data_mem_unit;

    localparam int ADDR_W = 18;
    localparam int LAT0   = 1;
    localparam int LAT1   = 3;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  valid = 2'b00;
    logic        we    = 1'b0;
    logic [1:0]  size  = 2'b00;
    logic        sgn   = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic              ready [2];
    logic              rv    [2];
    logic              rerr  [2];
    logic [31:0]       rdata [2];
    logic [ADDR_W-1:0] baddr [2];
    logic [31:0]       din   [2];
    logic [3:0]        bwe   [2];
    logic [31:0]       dout  [2];

    always #5 clk = ~clk;

    data_mem_unit #(.ADDR_W(ADDR_W), .READ_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rstn(rstn), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_we(we), .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv[0]), .resp_err(rerr[0]), .resp_rdata(rdata[0]),
        .bram_addr(baddr[0]), .bram_din(din[0]), .bram_we(bwe[0]), .bram_dout(dout[0])
    );

    data_mem_unit #(.ADDR_W(ADDR_W), .READ_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rstn(rstn), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_we(we), .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv[1]), .resp_err(rerr[1]), .resp_rdata(rdata[1]),
        .bram_addr(baddr[1]), .bram_din(din[1]), .bram_we(bwe[1]), .bram_dout(dout[1])
    );

    // BRAM stand-ins: byte-enabled write, read data delayed by each instance's latency
    logic [31:0] bmem [2][256] = '{default: 32'd0};
    logic [31:0] pipe [2][4];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++)
                if (bwe[d][i]) bmem[d][baddr[d][7:0]][8*i +: 8] <= din[d][8*i +: 8];
            pipe[d][0] <= bmem[d][baddr[d][7:0]];
            for (int i = 1; i < 4; i++) pipe[d][i] <= pipe[d][i-1];
        end
    end
    assign dout[0] = pipe[0][LAT0-1];
    assign dout[1] = pipe[1][LAT1-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state (request level)
    logic [31:0]       ref_mem   [2][256] = '{default: 32'd0};
    int                busy_from [2] = '{-1, -1};
    int                resp_cyc  [2] = '{-1, -1};
    int                we_cyc    [2] = '{-1, -1};
    int                addr_cyc  [2] = '{-1, -1};
    logic              exp_err   [2];
    logic [31:0]       exp_rdata [2];
    logic [31:0]       exp_din   [2];
    logic [3:0]        exp_we    [2];
    logic [ADDR_W-1:0] exp_baddr [2];
    logic [31:0]       hold_rdata[2] = '{32'd0, 32'd0};
    int                got_cyc   [2] = '{-1, -1};
    logic [31:0]       got_rdata [2] = '{32'd0, 32'd0};
    logic              got_err   [2] = '{1'b0, 1'b0};
    int                resp_cnt  [2] = '{0, 0};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] s,
                                             input logic sg, input int lane);
        logic [31:0] v;
        if (s == 2'd0) begin
            v = (w >> (8 * lane)) % 256;
            if (sg && v >= 128) v = v - 256;
        end else if (s == 2'd1) begin
            v = (w >> (8 * lane)) % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Per-cycle comparison of both instances against the model expectations
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                check($sformatf("rst_ctrl%0d", d), {28'd0, ready[d], rv[d], rerr[d], |bwe[d]}, 32'd0);
                check($sformatf("rst_data%0d", d), rdata[d] | din[d] | 32'(baddr[d]), 32'd0);
                hold_rdata[d] <= 32'd0;
            end else begin
                check($sformatf("ready%0d", d), 32'(ready[d]),
                      32'(!(cyc >= busy_from[d] && cyc <= resp_cyc[d])));
                if (cyc == resp_cyc[d]) begin
                    check($sformatf("resp%0d", d), {30'd0, rv[d], rerr[d]}, {30'd0, 1'b1, exp_err[d]});
                    check($sformatf("rdata%0d", d), rdata[d], exp_rdata[d]);
                    hold_rdata[d] <= exp_rdata[d];
                    got_cyc[d]    <= cyc;
                    got_rdata[d]  <= rdata[d];
                    got_err[d]    <= rerr[d];
                    resp_cnt[d]   <= resp_cnt[d] + 1;
                end else begin
                    check($sformatf("idle_resp%0d", d), {30'd0, rv[d], rerr[d]}, 32'd0);
                    check($sformatf("rdata_hold%0d", d), rdata[d], hold_rdata[d]);
                end
                check($sformatf("bram_we%0d", d), 32'(bwe[d]), (cyc == we_cyc[d]) ? 32'(exp_we[d]) : 32'd0);
                if (cyc == we_cyc[d]) check($sformatf("bram_din%0d", d), din[d], exp_din[d]);
                if (cyc == addr_cyc[d]) check($sformatf("bram_addr%0d", d), 32'(baddr[d]), 32'(exp_baddr[d]));
            end
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Model an accept of the currently driven request by instance d at the end of this cycle
    task automatic record(input int d);
        int c;
        int lane;
        int widx;
        logic err;
        logic [31:0] m;
        c    = cyc;
        lane = addr % 4;
        widx = (addr / 4) % 256;
        err  = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
               (size == 2'd2 && (addr % 4) != 0) || (addr >= (32'd1 << (ADDR_W + 2)));
        busy_from[d] = c + 1;
        we_cyc[d]    = -1;
        addr_cyc[d]  = -1;
        exp_err[d]   = err;
        exp_rdata[d] = 32'd0;
        if (err) begin
            resp_cyc[d] = c + 1;
        end else begin
            addr_cyc[d]  = c + 1;
            exp_baddr[d] = ADDR_W'(addr / 4);
            if (we) begin
                we_cyc[d]   = c + 1;
                resp_cyc[d] = c + 2;
                if (size == 2'd0) begin
                    exp_we[d]  = 4'(1 << lane);
                    exp_din[d] = (wdata % 256) * 32'h0101_0101;
                    m = 32'hFF << (8 * lane);
                end else if (size == 2'd1) begin
                    exp_we[d]  = 4'(3 << lane);
                    exp_din[d] = (wdata % 65536) * 32'h0001_0001;
                    m = 32'hFFFF << (8 * lane);
                end else begin
                    exp_we[d]  = 4'hF;
                    exp_din[d] = wdata;
                    m = 32'hFFFF_FFFF;
                end
                ref_mem[d][widx] = (ref_mem[d][widx] & ~m) | ((wdata << (8 * lane)) & m);
            end else begin
                exp_rdata[d] = ref_load(ref_mem[d][widx], size, sgn, lane);
                resp_cyc[d]  = c + 2 + ((d == 0) ? LAT0 : LAT1);
            end
        end
    endtask

    task automatic issue(input int d, input logic w, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        we = w; size = s; sgn = sg; addr = a; wdata = wd;
        valid[d] = 1'b1;
        record(d);
        wait_cycle();
        valid[d] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (cyc > resp_cyc[0] && cyc > resp_cyc[1]) break;
            wait_cycle();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int c;
        int n0;
        logic [1:0] rs;
        logic [31:0] ra;
        int r;

        repeat (3) wait_cycle();
        rstn = 1'b1;
        wait_cycle();

        // Word store then load on the latency-1 instance
        c = cyc;
        issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("st_word_we_model", 32'(exp_we[0]), 32'hF);
        check("st_word_addr_model", 32'(exp_baddr[0]), 32'd4);
        wait_idle();
        check("st_word_latency", 32'(got_cyc[0] - c), 32'd2);
        c = cyc;
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        wait_idle();
        check("ld_word_data", got_rdata[0], 32'hDEAD_BEEF);
        check("ld_word_latency", 32'(got_cyc[0] - c), 32'd3);

        // Byte store at lane 3 and both extensions
        issue(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5);
        check("st_byte_we_model", 32'(exp_we[0]), 32'h8);
        check("st_byte_din_model", exp_din[0], 32'hA5A5_A5A5);
        wait_idle();
        issue(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
        wait_idle();
        check("ld_byte_signed", got_rdata[0], 32'hFFFF_FFA5);
        issue(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
        wait_idle();
        check("ld_byte_unsigned", got_rdata[0], 32'h0000_00A5);

        // Upper half of the word becomes 0x8001
        issue(0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8001);
        wait_idle();
        issue(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
        wait_idle();
        check("ld_half_signed", got_rdata[0], 32'hFFFF_8001);
        issue(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
        wait_idle();
        check("ld_half_unsigned", got_rdata[0], 32'h0000_8001);

        // Error responses arrive one cycle after accept with zero data
        for (int k = 0; k < 4; k++) begin
            c = cyc;
            case (k)
                0: issue(0, 1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'd0);
                1: issue(0, 1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h1234);
                2: issue(0, 1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'd0);
                default: issue(0, 1'b0, 2'd2, 1'b0, 32'h0010_0000, 32'd0);
            endcase
            wait_idle();
            check($sformatf("err%0d_flag", k), 32'(got_err[0]), 32'd1);
            check($sformatf("err%0d_latency", k), 32'(got_cyc[0] - c), 32'd1);
            check($sformatf("err%0d_rdata", k), got_rdata[0], 32'd0);
        end

        // Latency-3 instance: store, load timing
        issue(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678);
        wait_idle();
        c = cyc;
        issue(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        wait_idle();
        check("l3_ld_data", got_rdata[1], 32'h1234_5678);
        check("l3_ld_latency", 32'(got_cyc[1] - c), 32'd5);

        // Held request: the second accept must wait until T+6
        c  = cyc;
        n0 = resp_cnt[1];
        we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h20; wdata = 32'd0;
        valid[1] = 1'b1;
        record(1);
        repeat (6) wait_cycle();
        check("held_first_resp", 32'(got_cyc[1] - c), 32'd5);
        record(1);
        wait_cycle();
        valid[1] = 1'b0;
        wait_idle();
        check("held_second_resp", 32'(got_cyc[1] - c), 32'd11);
        check("held_resp_count", 32'(resp_cnt[1] - n0), 32'd2);

        // Reset during a WAIT cycle aborts the load without a response
        issue(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        wait_cycle();
        n0 = resp_cnt[1];
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_ctrl", {28'd0, ready[1], rv[1], rerr[1], |bwe[1]}, 32'd0);
        check("rst_mid_data", rdata[1] | din[1] | 32'(baddr[1]), 32'd0);
        for (int d = 0; d < 2; d++) begin
            busy_from[d] = -1; resp_cyc[d] = -1; we_cyc[d] = -1; addr_cyc[d] = -1;
        end
        wait_cycle();
        wait_cycle();
        rstn = 1'b1;
        repeat (5) wait_cycle();
        check("rst_no_resp", 32'(resp_cnt[1] - n0), 32'd0);
        issue(1, 1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
        wait_idle();
        check("post_rst_load", got_rdata[1], 32'h0000_1234);

        // Randomized traffic on both instances
        for (int k = 0; k < 250; k++) begin
            r  = $urandom_range(0, 9);
            rs = (r == 0) ? 2'd3 : 2'(r % 3);
            if ($urandom_range(0, 15) == 0) ra = $urandom | 32'h0010_0000;
            else                            ra = 32'($urandom_range(0, 255));
            issue($urandom_range(0, 1), 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)),
                  ra, $urandom);
            wait_idle();
        end

        repeat (2) wait_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
